// File: rtl/branch_resolve_if.sv
// ---------------------------------------------------------------------------
// branch_resolve_if
// Groups the signals between the ID-stage branch resolve unit and its
// neighbours (ID operand/decode info, IF prediction, IF redirect handshake,
// later-stage flush, branch predictor update).
//   master : the pipeline side; drives the instruction, prediction,
//            flush_in and redirect_ready, and receives redirect, flush,
//            stall and predictor update.
//   slave  : the resolve unit itself.
// ---------------------------------------------------------------------------
interface branch_resolve_if #(
   parameter int XLEN = 32
);
   logic            id_valid;
   logic            is_sb_type;
   logic            is_jal;
   logic            is_jalr;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_imm;
   logic [XLEN-1:0] rs1_data;
   logic            zero;
   logic            opnd_ready;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;
   logic            flush_in;
   logic            redirect_ready;

   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            flush_ifid;
   logic            id_stall;
   logic            bp_upd_valid;
   logic [XLEN-1:0] bp_upd_pc;
   logic            bp_upd_taken;
   logic [XLEN-1:0] bp_upd_target;

   modport master (
      output id_valid, is_sb_type, is_jal, is_jalr, id_pc, id_imm, rs1_data,
             zero, opnd_ready, pred_taken, pred_target, flush_in,
             redirect_ready,
      input  redirect_valid, redirect_pc, flush_ifid, id_stall,
             bp_upd_valid, bp_upd_pc, bp_upd_taken, bp_upd_target
   );

   modport slave (
      input  id_valid, is_sb_type, is_jal, is_jalr, id_pc, id_imm, rs1_data,
             zero, opnd_ready, pred_taken, pred_target, flush_in,
             redirect_ready,
      output redirect_valid, redirect_pc, flush_ifid, id_stall,
             bp_upd_valid, bp_upd_pc, bp_upd_taken, bp_upd_target
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Resolves the slot-0 control-flow instruction in ID (SB-type, JAL, JALR)
// against the IF prediction. A mispredict raises a held redirect to IF
// together with an IF/ID flush; every resolution emits a one-cycle branch
// predictor update; mispredicts are counted in a saturating counter.
// ID is stalled while the branch operands cannot be forwarded yet.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   bus (slave)    : instruction/prediction inputs, redirect handshake,
//                    flush_ifid, id_stall, predictor update outputs
//   mispredict_cnt : saturating mispredict count
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   branch_resolve_if.slave    bus,
   output logic [CNT_W-1:0]   mispredict_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_REDIR
   } state_t;

   state_t state_q, state_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic            ctrl;
   logic            taken;
   logic [XLEN-1:0] target_sum;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] correct_pc;
   logic            mispredict;
   logic            resolve;
   logic            id_stall;

   logic            vld_p1;
   logic [XLEN-1:0] bp_pc_p1;
   logic            bp_taken_p1;
   logic [XLEN-1:0] bp_target_p1;
   logic [XLEN-1:0] redirect_pc_p1;
   logic [CNT_W-1:0] cnt_p1;

   // Stage 0: combinational outcome and target of the instruction in ID
   assign ctrl       = bus.id_valid & (bus.is_sb_type | bus.is_jal | bus.is_jalr);
   assign taken      = bus.is_sb_type ? bus.zero : 1'b1;
   assign target_sum = bus.is_jalr ? (bus.rs1_data + bus.id_imm)
                                   : (bus.id_pc + bus.id_imm);
   // JALR clears bit 0 of the computed address
   assign target     = bus.is_jalr ? (target_sum & ~XLEN'(1)) : target_sum;
   assign mispredict = (taken != bus.pred_taken) |
                       (taken & (bus.pred_target != target));
   assign correct_pc = taken ? target : bus.id_pc + XLEN'(4);

   // While a redirect is outstanding the ID contents are wrong-path
   assign resolve = (state_q != S_REDIR) & ctrl & bus.opnd_ready & ~bus.flush_in;

   always_comb begin
      state_d  = state_q;
      id_stall = 1'b0;
      if (bus.flush_in) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_WAIT: begin
               if (ctrl & ~bus.opnd_ready) begin
                  state_d  = S_WAIT;
                  id_stall = 1'b1;
               end else if (resolve & mispredict) begin
                  state_d = S_REDIR;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_REDIR: begin
               if (bus.redirect_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Stage 1: registered predictor update, redirect target and counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         vld_p1         <= 1'b0;
         bp_pc_p1       <= '0;
         bp_taken_p1    <= 1'b0;
         bp_target_p1   <= '0;
         redirect_pc_p1 <= '0;
         cnt_p1         <= '0;
      end else begin
         state_q <= state_d;
         vld_p1  <= resolve;
         if (resolve) begin
            bp_pc_p1     <= bus.id_pc;
            bp_taken_p1  <= taken;
            bp_target_p1 <= target;
         end
         if (resolve & mispredict) begin
            redirect_pc_p1 <= correct_pc;
            cnt_p1         <= sat_inc(cnt_p1);
         end
      end
   end

   assign bus.redirect_valid = (state_q == S_REDIR);
   assign bus.flush_ifid     = (state_q == S_REDIR);
   assign bus.redirect_pc    = redirect_pc_p1;
   assign bus.id_stall       = id_stall;
   assign bus.bp_upd_valid   = vld_p1;
   assign bus.bp_upd_pc      = bp_pc_p1;
   assign bus.bp_upd_taken   = bp_taken_p1;
   assign bus.bp_upd_target  = bp_target_p1;
   assign mispredict_cnt     = cnt_p1;

endmodule
